// File: rtl/mac_sequencer.sv
// mac_sequencer: walks two operand memories, issues each pair to an external mac
// and accumulates the products into a dot-product result.
module mac_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_a_din,
    input  logic [DATA_WIDTH-1:0] mem_b_din,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_start,
    input  logic [DATA_WIDTH-1:0] mac_dout,
    input  logic                  mac_busy
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, FINISH} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] len_q, index, addr_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [ADDR_WIDTH:0]   index_inc;
    logic                  last;
    // one extra bit so len == 2^ADDR_WIDTH-1 cannot alias through overflow
    assign index_inc = {1'b0, index} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last      = index_inc == {1'b0, len_q};
    assign busy      = state != IDLE;
    assign mac_start = state == ISSUE;
    assign mem_addr  = state == FETCH ? index : addr_q;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? (len == '0 ? FINISH : FETCH) : IDLE;
            FETCH:     state_n = LOAD;
            LOAD:      state_n = ISSUE;
            ISSUE:     state_n = WAIT_ACK;
            WAIT_ACK:  state_n = mac_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: state_n = mac_busy ? WAIT_DONE : (last ? FINISH : FETCH);
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            mac_a  <= '0;
            mac_b  <= '0;
            addr_q <= '0;
            acc    <= '0;
            index  <= '0;
            len_q  <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len_q <= len;
                    index <= '0;
                    acc   <= '0;
                end
                FETCH: addr_q <= index;
                LOAD: begin
                    mac_a <= mem_a_din;
                    mac_b <= mem_b_din;
                end
                WAIT_DONE: if (!mac_busy) begin
                    acc   <= acc + mac_dout;
                    index <= index_inc[ADDR_WIDTH-1:0];
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: random and directed dot-product runs against a sum-of-products
// reference, with a scoreboard checked whenever done pulses.
module tb_mac_sequencer;
    localparam int DW = 32;
    localparam int AW = 8;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, mac_busy = 1'b0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] mem_a_din = '0, mem_b_din = '0, mac_dout = '0;
    logic          busy, done, mac_start;
    logic [DW-1:0] result, mac_a, mac_b;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .result(result), .mem_addr(mem_addr), .mem_a_din(mem_a_din), .mem_b_din(mem_b_din),
        .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start), .mac_dout(mac_dout),
        .mac_busy(mac_busy)
    );

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    always @(posedge clk) begin
        mem_a_din <= mem_a[mem_addr];
        mem_b_din <= mem_b[mem_addr];
    end

    // mac model: busy rises ack_delay+2 cycles after mac_start, lasts busy_cycles
    int            ack_delay = 0, busy_cycles = 4, dly = 0, bcnt = 0;
    logic          pending = 1'b0;
    logic [DW-1:0] prod = '0;
    always @(posedge clk) begin
        if (mac_start) begin
            pending <= 1'b1;
            dly     <= ack_delay;
            prod    <= mac_a * mac_b;
        end else if (pending) begin
            if (dly == 0) begin
                pending  <= 1'b0;
                mac_busy <= 1'b1;
                bcnt     <= busy_cycles;
            end else dly <= dly - 1;
        end else if (mac_busy) begin
            if (bcnt <= 1) begin
                mac_busy <= 1'b0;
                mac_dout <= prod;
            end else bcnt <= bcnt - 1;
        end
    end

    typedef struct {
        logic [DW-1:0] res;
        int            starts;
    } exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0, done_cnt = 0, start_cnt = 0, exp_idx = 0;
    logic prev_ms = 1'b0, prev_busy = 1'b0, hold = 1'b0;
    logic [DW-1:0] ca = '0, cb = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            start_cnt = 0;
            hold      = 1'b0;
        end else begin
            if (mac_start) begin
                chk("mac_start_one_cycle", prev_ms, 1'b0);
                chk("mem_addr_seq", mem_addr, exp_idx);
                exp_idx++;
                start_cnt++;
                ca   = mac_a;
                cb   = mac_b;
                hold = 1'b1;
            end
            if (hold && prev_busy && !mac_busy) begin
                chk("mac_a_stable", mac_a, ca);
                chk("mac_b_stable", mac_b, cb);
                hold = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) chk("unexpected_done", done, 1'b0);
                else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("mac_start_count", start_cnt, e.starts);
                end
                start_cnt = 0;
            end
        end
        prev_ms   = mac_start;
        prev_busy = mac_busy;
    end

    task automatic push_exp(input int n);
        exp_t          e;
        logic [DW-1:0] sum;
        sum = '0;
        for (int i = 0; i < n; i++) sum = sum + DW'(64'(mem_a[i]) * 64'(mem_b[i]));
        e.res    = sum;
        e.starts = n;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input int ad, input int bc, input int restart_at);
        int d0, cyc;
        ack_delay   = ad;
        busy_cycles = bc;
        push_exp(n);
        @(negedge clk);
        d0      = done_cnt;
        exp_idx = 0;
        start   = 1'b1;
        len     = AW'(n);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == restart_at) len = AW'(3);
        end
        start = 1'b0;
        chk("run_finished_in_budget", 64'(cyc < 20000), 64'd1);
    endtask

    initial begin
        int cyc, bad;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mac_start", mac_start, 1'b0);
        chk("rst_result", result, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        mem_a[0] = 5; mem_b[0] = 3;
        run(1, 0, 4, 0);
        chk("single_pair_15", result, 15);

        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        run(4, 0, 4, 0);
        chk("four_pairs_70", result, 70);
        chk("mem_addr_hold", mem_addr, 3);

        // zero-length run: busy one cycle, done two cycles after start
        push_exp(0);
        @(negedge clk);
        start = 1'b1; len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_busy_c1", busy, 1'b1);
        chk("len0_done_c1", done, 1'b0);
        @(negedge clk);
        chk("len0_done_c2", done, 1'b1);
        chk("len0_busy_c2", busy, 1'b0);
        chk("len0_result", result, 0);

        mem_a[0] = 32'hFFFF_FFFF; mem_b[0] = 1;
        mem_a[1] = 2;             mem_b[1] = 1;
        run(2, 1, 3, 0);
        chk("wrap_result", result, 1);

        mem_a[0] = 9; mem_b[0] = 11;
        run(1, 1, 4, 3);
        chk("restart_ignored", result, 99);

        // abort mid-run: no done, then a fresh run
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        ack_delay = 0; busy_cycles = 6;
        push_exp(4);
        @(negedge clk);
        exp_idx = 0;
        start = 1'b1; len = AW'(4);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(start_cnt == 2 && mac_busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_wait_done", 64'(cyc < 200), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || done || mac_start) bad++;
        end
        chk("idle_ignores_stale_mac", bad, 0);
        cyc = 0;
        while (mac_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        mem_a[0] = 7; mem_b[0] = 6;
        run(1, 0, 2, 0);
        chk("post_abort_42", result, 42);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                mem_a[i] = $urandom;
                mem_b[i] = $urandom;
            end
            run(n, $urandom_range(0, 3), $urandom_range(1, 5), (r % 2) ? $urandom_range(1, 10) : 0);
        end

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        run(255, 0, 1, 0);
        chk("max_len_sb_drained", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
